aes_key_expand: RTL and testbench
=================================

# aes_key_expand

Iterative, parametrised AES key-schedule engine. It accepts a 128/192/256-bit cipher key over a valid/ready handshake and produces one 32-bit expanded word per cycle. Words are packed into 128-bit round keys, which are streamed in round order over a second valid/ready handshake. The block feeds the round-key input of the AddRoundKey stage in the iterative cipher datapath, so the full key schedule is never held in memory.

## Interface
- KEY_BITS, 128, cipher key width; legal values are 128, 192 and 256. Derived values: NK = KEY_BITS/32, NR = NK+6, NW = 4*(NR+1) (44, 52 or 60 words).
- clk  in  1  single clock; all state updates on the rising edge.
- rst  in  1  reset, asynchronous and active-high.
- key_in  in  KEY_BITS  cipher key; bits [KEY_BITS-1 -: 32] hold w[0] (FIPS-197 byte order).
- key_valid  in  1  key offered.
- key_ready  out  1  engine idle; a key is accepted on key_valid && key_ready.
- rk_out  out  128  round key; bits [127:96] hold the lowest-index word.
- rk_round  out  4  round index of rk_out, 0..NR.
- rk_last  out  1  high together with rk_valid when rk_round == NR.
- rk_valid  out  1  round key held in the output register.
- rk_ready  in  1  consumer accepts; transfer on rk_valid && rk_ready.
- busy  out  1  high in every state other than IDLE.

## Operation
- FSM states: IDLE, EXPAND, DRAIN.
  - IDLE → EXPAND on key handshake. The key is loaded into an NK-word sliding window, and the word counter i = 0 and rcon = 0x01 are cleared/initialised.
  - EXPAND → DRAIN when word NW-1 is transferred to the output register.
  - DRAIN → IDLE when the rk_last key is accepted.
- key_ready = (state == IDLE). key_valid outside IDLE is ignored; the held key_in is not sampled.
- Word generation for i < NK: w[i] is the loaded key word.
- Word generation for i ≥ NK: w[i] = w[i-NK] ^ t, where:
  - if i mod NK == 0: t = SubWord(RotWord(w[i-1])) ^ {rcon, 24'h0}, and rcon is then updated to xtime(rcon) (GF(2^8), modulus 0x11B);
  - else if NK == 8 and i mod NK == 4: t = SubWord(w[i-1]);
  - otherwise: t = w[i-1].
- Each generated word shifts into the window and appends to a 4-word accumulator.
- The 4th word of a group is written straight into rk_out together with the three accumulated words. rk_round increments and rk_valid is set.
- Stall rule: if the 4th word of a group is due while rk_valid is high and rk_ready is low, generation holds. i, the window, rcon and the accumulator all freeze. Words 0–2 of the next group may still be generated while the output is held.
- All arithmetic is XOR or GF(2^8); there are no carries. i is ceil(log2(NW))+1 bits wide and never wraps within one key.

## Timing
- Reset values:
  - outputs: key_ready 1, busy 0, rk_valid 0, rk_last 0, rk_round 0, rk_out 0;
  - internal: state IDLE, i 0, rcon 0x01.
- With the key handshake at edge E0, word w[i] is generated at edge E(i+1). Round key r becomes valid after edge E(4r+4) when rk_ready is held high.
- Throughput is one round key per 4 cycles, with no bubbles while rk_ready is high.
- Key accepted to last key: 4*(NR+1) cycles (44, 52 or 60) when unstalled.
- rk_out, rk_round and rk_last are stable while rk_valid && !rk_ready.
- key_ready rises in the cycle after the rk_last handshake. Back-to-back keys lose no further cycles.
- rst asserted mid-expansion aborts the expansion immediately. All outputs return to their reset values and no partial key is emitted afterwards.

## Configuration
- AES_KEY_EXPAND_CACHE_EN defined:
  - Adds an input port replay_req (1 bit) and a (NR+1)×128 round-key store, written as each key is emitted.
  - In IDLE, after at least one complete expansion, replay_req high (with key_valid low) enters state REPLAY.
  - REPLAY re-emits rounds 0..NR from the store, one per accepted cycle, without recomputation. It returns to IDLE after the rk_last handshake.
  - key_valid has priority over replay_req. rst invalidates the store.
- Not defined: no replay_req port, no store and no REPLAY state. Every key use recomputes the schedule.

## Structure
- Package aes_pkg holds:
  - word_t (32-bit) and block_t (128-bit);
  - the key-expansion FSM state enum;
  - the S-box constant table;
  - xtime, RotWord and SubWord functions;
  - localparams deriving NK, NR and NW from KEY_BITS.
- Sub-module aes_sbox: combinational 8-bit S-box lookup, instantiated 4× to form SubWord.

## Test plan
- AES-128 key 2b7e151628aed2a6abf7158809cf4f3c, rk_ready = 1:
  - round 1 = a0fafe1788542cb123a339392a6c7605;
  - round 10 = d014f9a8c9ee2589e13f0cc8b6630ca6 with rk_last;
  - round 10 valid after edge E44.
- AES-192 key 8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b: round 1 = 62f8ead2522c6b7bfe0c91f72402f5a5 (straddles the key and the first generated words).
- AES-256 key 603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4:
  - round 2 = 9ba354118e6925afa51a8b5f2067fcde;
  - round 14 = fe4890d1e6188d0b046df344706c631e.
- Backpressure: rk_ready low for 7 cycles while round 3 is held → rk_out and rk_round stable for the whole hold, generation stalls, and the sequence is unchanged afterwards.
- Reset mid-expansion: assert rst after round 4 → key_ready = 1 and rk_valid = 0 immediately. A new key then yields the correct round 0.
- With AES_KEY_EXPAND_CACHE_EN: after an AES-128 expansion, pulse replay_req → the same 11 round keys are emitted, one per cycle with rk_ready high, and the last has rk_last.

Source files
------------

// File: rtl/aes_pkg.sv
`default_nettype none
// ============================================================================
// Module      : aes_pkg
// Description : Shared types, FSM state encoding, S-box table and word
//               helper functions for the AES key-schedule engine.
//               Contents:
//                 word_t / block_t   32-bit word and 128-bit block types
//                 kx_state_t         key-expansion FSM state encoding
//                 SBOX               forward AES S-box table
//                 xtime/rot_word/sub_word helpers
//                 aes_nk/aes_nr/aes_nw derive NK, NR, NW from a key width
// Revision    : 1.0 - initial release
// ============================================================================
package aes_pkg;

  typedef logic [31:0]  word_t;
  typedef logic [127:0] block_t;

  // REPLAY is only reachable when the round-key store is built in.
  typedef enum logic [1:0] {
    KX_IDLE   = 2'd0,
    KX_EXPAND = 2'd1,
    KX_DRAIN  = 2'd2,
    KX_REPLAY = 2'd3
  } kx_state_t;

  localparam int KEY_BITS_DEFAULT = 128;
  localparam int NK_DEFAULT       = KEY_BITS_DEFAULT / 32;
  localparam int NR_DEFAULT       = NK_DEFAULT + 6;
  localparam int NW_DEFAULT       = 4 * (NR_DEFAULT + 1);

  function automatic int aes_nk(input int key_bits);
    return key_bits / 32;
  endfunction

  function automatic int aes_nr(input int key_bits);
    return key_bits / 32 + 6;
  endfunction

  function automatic int aes_nw(input int key_bits);
    return 4 * (key_bits / 32 + 7);
  endfunction

  localparam logic [7:0] SBOX [0:255] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  // Multiply by x in GF(2^8) modulo x^8+x^4+x^3+x+1.
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic word_t rot_word(input word_t w);
    return {w[23:0], w[31:24]};
  endfunction

  function automatic word_t sub_word(input word_t w);
    return {SBOX[w[31:24]], SBOX[w[23:16]], SBOX[w[15:8]], SBOX[w[7:0]]};
  endfunction

endpackage : aes_pkg
`default_nettype wire

// File: rtl/aes_sbox.sv
`default_nettype none
// ============================================================================
// Module      : aes_sbox
// Description : Combinational forward AES S-box, one byte.
//               Ports:
//                 a  in  8  input byte
//                 y  out 8  substituted byte
// Revision    : 1.0 - initial release
// ============================================================================
module aes_sbox
  import aes_pkg::*;
(
  input  logic [7:0] a,
  output logic [7:0] y
);

  assign y = SBOX[a];

endmodule : aes_sbox
`default_nettype wire

// File: rtl/aes_key_expand.sv
`default_nettype none
// ============================================================================
// Module      : aes_key_expand
// Description : Iterative AES key-schedule engine. Accepts a 128/192/256-bit
//               key, generates one expanded word per cycle and streams
//               128-bit round keys in round order.
//               Ports:
//                 clk, rst        clock, asynchronous active-high reset
//                 key_in          cipher key, w[0] in the top 32 bits
//                 key_valid/ready key handshake (ready only when idle)
//                 rk_out          round key, lowest word in [127:96]
//                 rk_round        round index 0..NR
//                 rk_last         marks round NR
//                 rk_valid/ready  round-key handshake
//                 busy            engine not idle
//                 replay_req      (AES_KEY_EXPAND_CACHE_EN only) re-emit the
//                                 stored schedule without recomputation
//               Build option: define AES_KEY_EXPAND_CACHE_EN to add the
//               round-key store, the REPLAY state and the replay_req port.
// Revision    : 1.0 - initial release
// ============================================================================
module aes_key_expand
  import aes_pkg::*;
#(
  parameter int KEY_BITS = 128
)
(
  input  logic                clk,
  input  logic                rst,
  input  logic [KEY_BITS-1:0] key_in,
  input  logic                key_valid,
  output logic                key_ready,
  output logic [127:0]        rk_out,
  output logic [3:0]          rk_round,
  output logic                rk_last,
  output logic                rk_valid,
  input  logic                rk_ready,
`ifdef AES_KEY_EXPAND_CACHE_EN
  input  logic                replay_req,
`endif
  output logic                busy
);

  localparam int NK = aes_nk(KEY_BITS);
  localparam int NR = aes_nr(KEY_BITS);
  localparam int NW = aes_nw(KEY_BITS);
  localparam int IW = $clog2(NW) + 1;

  localparam logic [IW-1:0] NK_I   = IW'(NK);
  localparam logic [IW-1:0] I_LAST = IW'(NW - 1);
  localparam logic [2:0]    K_LAST = 3'(NK - 1);

  kx_state_t           state;
  logic [IW-1:0]       widx;      // index i of the word generated next
  logic [2:0]          kmod;      // i mod NK, tracked incrementally
  logic [7:0]          rcon;
  logic [KEY_BITS-1:0] win;       // top word = w[i-NK], bottom word = w[i-1]
  logic [95:0]         acc;       // words 0..2 of the group being built

  word_t oldest;
  word_t prev;
  word_t sub_in;
  word_t sub_out;
  word_t t_word;
  word_t new_word;
  logic  is_key;
  logic  mod0;
  logic  mod4;
  logic  group_end;
  logic  last_word;
  logic  stall;
  logic  step;

  assign oldest    = win[KEY_BITS-1 -: 32];
  assign prev      = win[31:0];
  assign is_key    = (widx < NK_I);
  assign mod0      = (kmod == 3'd0);
  assign mod4      = (NK == 8) && (kmod == 3'd4);
  assign group_end = (widx[1:0] == 2'b11);
  assign last_word = (widx == I_LAST);

  // A finished round key can only be overwritten once the consumer has it.
  assign stall = group_end && rk_valid && !rk_ready;
  assign step  = (state == KX_EXPAND) && !stall;

  // One shared SubWord serves both the RotWord case and the 256-bit i%8==4 case.
  assign sub_in = mod0 ? rot_word(prev) : prev;

  for (genvar k = 0; k < 4; k++) begin : g_sbox
    aes_sbox u_sbox (
      .a (sub_in[8*k +: 8]),
      .y (sub_out[8*k +: 8])
    );
  end

  always_comb begin
    t_word = prev;
    if (mod0) begin
      t_word = sub_out ^ {rcon, 24'h0};
    end else if (mod4) begin
      t_word = sub_out;
    end
  end

  // While i < NK the window simply rotates, re-emitting the key words; after
  // NK rotations it holds w[0..NK-1] again, ready for the recurrence.
  assign new_word = is_key ? oldest : (oldest ^ t_word);

  assign key_ready = (state == KX_IDLE);
  assign busy      = (state != KX_IDLE);

`ifdef AES_KEY_EXPAND_CACHE_EN
  block_t     store [0:NR];
  logic       store_ok;
  logic [3:0] rp_idx;

  always_ff @(posedge clk) begin
    if (step && group_end) begin
      store[widx[5:2]] <= {acc, new_word};
    end
  end
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= KX_IDLE;
      widx     <= '0;
      kmod     <= 3'd0;
      rcon     <= 8'h01;
      win      <= '0;
      acc      <= '0;
      rk_out   <= '0;
      rk_round <= 4'd0;
      rk_last  <= 1'b0;
      rk_valid <= 1'b0;
`ifdef AES_KEY_EXPAND_CACHE_EN
      store_ok <= 1'b0;
      rp_idx   <= 4'd0;
`endif
    end else begin
      case (state)
        KX_IDLE: begin
          if (key_valid) begin
            win   <= key_in;
            widx  <= '0;
            kmod  <= 3'd0;
            rcon  <= 8'h01;
            state <= KX_EXPAND;
`ifdef AES_KEY_EXPAND_CACHE_EN
          end else if (replay_req && store_ok) begin
            rp_idx <= 4'd0;
            state  <= KX_REPLAY;
`endif
          end
        end

        KX_EXPAND: begin
          if (rk_valid && rk_ready) begin
            rk_valid <= 1'b0;
          end
          if (step) begin
            win  <= {win[KEY_BITS-33:0], new_word};
            widx <= widx + 1'b1;
            kmod <= (kmod == K_LAST) ? 3'd0 : kmod + 3'd1;
            if (!is_key && mod0) begin
              rcon <= xtime(rcon);
            end
            if (group_end) begin
              rk_out   <= {acc, new_word};
              rk_round <= widx[5:2];
              rk_last  <= last_word;
              rk_valid <= 1'b1;
              if (last_word) begin
                state <= KX_DRAIN;
              end
            end else begin
              acc <= {acc[63:0], new_word};
            end
          end
        end

        KX_DRAIN: begin
          if (rk_valid && rk_ready) begin
            rk_valid <= 1'b0;
            rk_last  <= 1'b0;
            state    <= KX_IDLE;
`ifdef AES_KEY_EXPAND_CACHE_EN
            store_ok <= 1'b1;
`endif
          end
        end

`ifdef AES_KEY_EXPAND_CACHE_EN
        KX_REPLAY: begin
          if (rk_valid && rk_ready && rk_last) begin
            rk_valid <= 1'b0;
            rk_last  <= 1'b0;
            state    <= KX_IDLE;
          end else if ((!rk_valid || rk_ready) && (rp_idx <= 4'(NR))) begin
            rk_out   <= store[rp_idx];
            rk_round <= rp_idx;
            rk_last  <= (rp_idx == 4'(NR));
            rk_valid <= 1'b1;
            rp_idx   <= rp_idx + 4'd1;
          end else if (rk_valid && rk_ready) begin
            rk_valid <= 1'b0;
          end
        end
`endif

        default: begin
          state <= KX_IDLE;
        end
      endcase
    end
  end

endmodule : aes_key_expand
`default_nettype wire

// File: tb/tb_aes_key_expand.sv
`default_nettype none
// ============================================================================
// Module      : tb_aes_key_expand
// Description : Self-checking bench for aes_key_expand. Three instances
//               (128/192/256-bit keys) share clock, reset and rk_ready; a
//               reference key schedule (S-box built from the GF(2^8) inverse
//               and affine map) fills a scoreboard queue that is drained as
//               round keys are handed over.
//               Build option: AES_KEY_EXPAND_CACHE_EN adds a replay check.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_aes_key_expand;

  typedef struct packed {
    logic         last;
    logic [3:0]   rnd;
    logic [127:0] rk;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  logic rk_ready;
  int   sel;
  int   n_cmp = 0;
  int   n_bad = 0;

  logic [127:0] key128;
  logic [191:0] key192;
  logic [255:0] key256;
  logic         kv128, kv192, kv256;
  logic         kr128, kr192, kr256;
  logic [127:0] out128, out192, out256;
  logic [3:0]   rnd128, rnd192, rnd256;
  logic         last128, last192, last256;
  logic         val128, val192, val256;
  logic         busy128, busy192, busy256;
`ifdef AES_KEY_EXPAND_CACHE_EN
  logic         replay_req;
`endif

  logic [127:0] m_out;
  logic [3:0]   m_rnd;
  logic         m_last, m_val, m_kr, m_busy;

  exp_t         exp_q[$];
  logic [31:0]  mw [0:59];
  logic [127:0] cap [0:15];

  always #5 clk = ~clk;

  aes_key_expand #(.KEY_BITS(128)) dut128 (
    .clk(clk), .rst(rst), .key_in(key128), .key_valid(kv128), .key_ready(kr128),
    .rk_out(out128), .rk_round(rnd128), .rk_last(last128), .rk_valid(val128),
    .rk_ready(rk_ready),
`ifdef AES_KEY_EXPAND_CACHE_EN
    .replay_req(replay_req),
`endif
    .busy(busy128));

  aes_key_expand #(.KEY_BITS(192)) dut192 (
    .clk(clk), .rst(rst), .key_in(key192), .key_valid(kv192), .key_ready(kr192),
    .rk_out(out192), .rk_round(rnd192), .rk_last(last192), .rk_valid(val192),
    .rk_ready(rk_ready),
`ifdef AES_KEY_EXPAND_CACHE_EN
    .replay_req(1'b0),
`endif
    .busy(busy192));

  aes_key_expand #(.KEY_BITS(256)) dut256 (
    .clk(clk), .rst(rst), .key_in(key256), .key_valid(kv256), .key_ready(kr256),
    .rk_out(out256), .rk_round(rnd256), .rk_last(last256), .rk_valid(val256),
    .rk_ready(rk_ready),
`ifdef AES_KEY_EXPAND_CACHE_EN
    .replay_req(1'b0),
`endif
    .busy(busy256));

  always_comb begin
    m_out = out128; m_rnd = rnd128; m_last = last128; m_val = val128; m_kr = kr128; m_busy = busy128;
    if (sel == 1) begin
      m_out = out192; m_rnd = rnd192; m_last = last192; m_val = val192; m_kr = kr192; m_busy = busy192;
    end else if (sel == 2) begin
      m_out = out256; m_rnd = rnd256; m_last = last256; m_val = val256; m_kr = kr256; m_busy = busy256;
    end
  end

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x, y;
    p = 8'h00; x = a; y = b;
    for (int k = 0; k < 8; k++) begin
      if (y[0]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
      y = y >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] sbox_ref(input logic [7:0] x);
    logic [7:0] r;
    r = 8'h00;
    if (x != 8'h00) begin
      r = 8'h01;
      for (int k = 0; k < 254; k++) r = gmul(r, x);
    end
    return r ^ {r[6:0], r[7]} ^ {r[5:0], r[7:6]} ^ {r[4:0], r[7:5]} ^ {r[3:0], r[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [31:0] subw_ref(input logic [31:0] w);
    return {sbox_ref(w[31:24]), sbox_ref(w[23:16]), sbox_ref(w[15:8]), sbox_ref(w[7:0])};
  endfunction

  // kv is left-aligned: w[0] in kv[255:224].
  task automatic model_push(input int nk, input logic [255:0] kv);
    int nr, nw;
    logic [7:0]  rc;
    logic [31:0] t;
    exp_t        e;
    nr = nk + 6; nw = 4 * (nr + 1); rc = 8'h01;
    for (int j = 0; j < nk; j++) mw[j] = kv[255 - 32*j -: 32];
    for (int j = nk; j < nw; j++) begin
      t = mw[j-1];
      if (j % nk == 0) begin
        t  = subw_ref({t[23:0], t[31:24]}) ^ {rc, 24'h0};
        rc = {rc[6:0], 1'b0} ^ (rc[7] ? 8'h1b : 8'h00);
      end else if (nk == 8 && j % nk == 4) begin
        t = subw_ref(t);
      end
      mw[j] = mw[j-nk] ^ t;
    end
    for (int r = 0; r <= nr; r++) begin
      e.last = (r == nr);
      e.rnd  = 4'(r);
      e.rk   = {mw[4*r], mw[4*r+1], mw[4*r+2], mw[4*r+3]};
      exp_q.push_back(e);
    end
  endtask

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk) begin
    if (!rst && m_val && rk_ready) begin
      if (exp_q.size() == 0) begin
        check("spurious_rk_valid", 128'(m_val), 128'(0));
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("rk_out", m_out, e.rk);
        check("rk_round", 128'(m_rnd), 128'(e.rnd));
        check("rk_last", 128'(m_last), 128'(e.last));
        cap[m_rnd] = m_out;
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic start_key(input int s, input logic [255:0] kv);
    sel = s;
    model_push(4 + 2*s, kv);
    if (s == 0) begin key128 = kv[255:128]; kv128 = 1'b1; end
    else if (s == 1) begin key192 = kv[255:64]; kv192 = 1'b1; end
    else begin key256 = kv; kv256 = 1'b1; end
    @(posedge clk); #1;
    kv128 = 1'b0; kv192 = 1'b0; kv256 = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int n;
    n = 0;
    while (!(exp_q.size() == 0 && m_kr) && n < 400) begin
      @(posedge clk); #1;
      n++;
    end
    check({tag, "_completes"}, 128'(exp_q.size() == 0 && m_kr), 128'(1));
  endtask

  task automatic wait_round(input int r, input string tag);
    int n;
    n = 0;
    while (!(m_val && m_rnd == 4'(r)) && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    check({tag, "_round_seen"}, 128'(m_val && m_rnd == 4'(r)), 128'(1));
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    logic [255:0] k;
    logic [127:0] exp3;
    rst = 1'b1; rk_ready = 1'b1; sel = 0;
    kv128 = 1'b0; kv192 = 1'b0; kv256 = 1'b0;
    key128 = '0; key192 = '0; key256 = '0;
`ifdef AES_KEY_EXPAND_CACHE_EN
    replay_req = 1'b0;
`endif
    repeat (3) @(posedge clk);
    #1;
    check("reset_key_ready", 128'(kr128), 128'(1));
    check("reset_busy", 128'(busy128), 128'(0));
    check("reset_rk_valid", 128'(val128), 128'(0));
    check("reset_rk_last", 128'(last128), 128'(0));
    check("reset_rk_round", 128'(rnd128), 128'(0));
    check("reset_rk_out", out128, 128'(0));
    rst = 1'b0;
    @(posedge clk); #1;

    // AES-128 FIPS-197 key with latency checks.
    start_key(0, {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0});
    repeat (43) @(posedge clk);
    #1;
    check("a128_e43_round", 128'(m_rnd), 128'(9));
    check("a128_e43_busy", 128'(m_busy), 128'(1));
    check("a128_e43_key_ready", 128'(m_kr), 128'(0));
    @(posedge clk); #1;
    check("a128_e44_valid", 128'(m_val), 128'(1));
    check("a128_e44_round", 128'(m_rnd), 128'(10));
    check("a128_e44_last", 128'(m_last), 128'(1));
    check("a128_e44_rk", m_out, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
    @(posedge clk); #1;
    check("a128_key_ready_after_last", 128'(m_kr), 128'(1));
    wait_done("a128");
    check("a128_round1", cap[1], 128'ha0fafe1788542cb123a339392a6c7605);

`ifdef AES_KEY_EXPAND_CACHE_EN
    begin
      int n;
      model_push(4, {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0});
      replay_req = 1'b1;
      @(posedge clk); #1;
      replay_req = 1'b0;
      n = 0;
      while (exp_q.size() != 0 && n < 40) begin
        @(posedge clk); #1;
        n++;
      end
      check("replay_drained", 128'(exp_q.size()), 128'(0));
      check("replay_one_per_cycle", 128'(n <= 12), 128'(1));
      wait_done("replay");
    end
`endif

    // AES-192: round 1 straddles key words and generated words.
    start_key(1, {192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b, 64'h0});
    wait_done("a192");
    check("a192_round1", cap[1], 128'h62f8ead2522c6b7bfe0c91f72402f5a5);

    // AES-256.
    start_key(2, 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4);
    wait_done("a256");
    check("a256_round2", cap[2], 128'h9ba354118e6925afa51a8b5f2067fcde);
    check("a256_round14", cap[14], 128'hfe4890d1e6188d0b046df344706c631e);

    // Back-to-back AES-192 keys with random content.
    for (int b = 0; b < 2; b++) begin
      k = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, 64'h0};
      start_key(1, k);
      wait_done("a192_b2b");
    end

    // Backpressure on round 3, plus a key offered mid-expansion (ignored).
    k = {$urandom, $urandom, $urandom, $urandom, 128'h0};
    start_key(0, k);
    exp3 = {mw[12], mw[13], mw[14], mw[15]};
    repeat (2) @(posedge clk);
    #1;
    key128 = ~k[255:128]; kv128 = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    kv128 = 1'b0;
    wait_round(3, "bp");
    rk_ready = 1'b0;
    for (int c = 0; c < 7; c++) begin
      @(posedge clk); #1;
      check("bp_hold_valid", 128'(m_val), 128'(1));
      check("bp_hold_round", 128'(m_rnd), 128'(3));
      check("bp_hold_rk", m_out, exp3);
    end
    rk_ready = 1'b1;
    wait_done("bp");

    // Reset in the middle of an AES-256 expansion.
    k = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    start_key(2, k);
    wait_round(4, "rst_mid");
    rst = 1'b1;
    #1;
    check("rst_mid_key_ready", 128'(m_kr), 128'(1));
    check("rst_mid_rk_valid", 128'(m_val), 128'(0));
    check("rst_mid_busy", 128'(m_busy), 128'(0));
    check("rst_mid_rk_out", m_out, 128'(0));
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_mid_no_partial", 128'(m_val), 128'(0));
    k = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    start_key(2, k);
    wait_done("after_rst");
    check("after_rst_round0", cap[0], k[255:128]);

    repeat (2) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired: observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule : tb_aes_key_expand
`default_nettype wire
